// File: rtl/jk_reg_pkg.sv
// Package jk_reg_pkg
//  Shared types and constants for the JK register bank.
//  - jk_mode_t    : bank operating mode (HOLD, JK, LOAD, COUNT)
//  - JK_ACT_*     : per-bit {j,k} action encodings used by jk_bit_cell
package jk_reg_pkg;

  typedef enum logic [1:0] {
    JK_HOLD  = 2'b00,
    JK_JK    = 2'b01,
    JK_LOAD  = 2'b10,
    JK_COUNT = 2'b11
  } jk_mode_t;

  localparam logic [1:0] JK_ACT_HOLD   = 2'b00;
  localparam logic [1:0] JK_ACT_CLEAR  = 2'b01;
  localparam logic [1:0] JK_ACT_SET    = 2'b10;
  localparam logic [1:0] JK_ACT_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_bit_cell.sv
// Module jk_bit_cell
//  A single JK flip-flop with synchronous active-low reset and clock enable.
//  Ports:
//    clk     in  rising-edge clock
//    rst_n   in  synchronous reset, active-low (loads rst_val)
//    en      in  clock enable; 0 holds state
//    j, k    in  JK inputs: 00 hold, 01 clear, 10 set, 11 toggle
//    rst_val in  value loaded on reset
//    q       out flip-flop state
module jk_bit_cell
  import jk_reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= rst_val;
    end else if (en) begin
      case ({j, k})
        JK_ACT_HOLD:   q_reg <= q_reg;
        JK_ACT_CLEAR:  q_reg <= 1'b0;
        JK_ACT_SET:    q_reg <= 1'b1;
        JK_ACT_TOGGLE: q_reg <= ~q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_reg_bank.sv
// Module jk_reg_bank
//  WIDTH-bit bank of JK flip-flops with a mode select: HOLD, per-bit JK,
//  parallel LOAD, or synchronous up/down COUNT built from JK toggle terms.
//  Optional macro JKREG_SATURATE_EN: when defined, COUNT mode stops at the
//  terminal count (all-ones up / zero down) instead of wrapping.
//  Ports:
//    clk      in   rising-edge clock
//    rst_n    in   synchronous reset, active-low (q <= RESET_VAL)
//    en       in   global enable; 0 holds all state
//    mode     in   00 HOLD, 01 JK, 10 LOAD, 11 COUNT
//    j, k     in   per-bit JK inputs (JK mode)
//    d        in   parallel load data (LOAD mode)
//    up       in   count direction, 1 = up (COUNT mode)
//    q        out  register state
//    qb       out  ~q, combinational
//    tc       out  terminal count, combinational
//    changed  out  registered; high one cycle after any q bit changed
module jk_reg_bank
  import jk_reg_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             changed
);

  jk_mode_t         mode_sel;
  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] j_cell;
  logic [WIDTH-1:0] k_cell;
  logic [WIDTH-1:0] toggle_raw;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] q_next;
  // ones_below[i] / zeros_below[i]: all bits below i are 1 / 0.
  // Index WIDTH covers the whole word and doubles as the terminal-count term.
  logic [WIDTH:0]   ones_below;
  logic [WIDTH:0]   zeros_below;
  logic             changed_reg;

  assign mode_sel       = jk_mode_t'(mode);
  assign ones_below[0]  = 1'b1;
  assign zeros_below[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign ones_below[gi+1]  = ones_below[gi] & q_bits[gi];
      assign zeros_below[gi+1] = zeros_below[gi] & ~q_bits[gi];
      assign toggle_raw[gi]    = up ? ones_below[gi] : zeros_below[gi];

      jk_bit_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .j       (j_cell[gi]),
        .k       (k_cell[gi]),
        .rst_val (RESET_VAL[gi]),
        .q       (q_bits[gi])
      );
    end
  endgenerate

  assign tc = en & (mode_sel == JK_COUNT) &
              (up ? ones_below[WIDTH] : zeros_below[WIDTH]);

`ifdef JKREG_SATURATE_EN
  // At the terminal count all toggles are masked, so the bank sits still.
  assign toggle = toggle_raw & {WIDTH{~tc}};
`else
  assign toggle = toggle_raw;
`endif

  // Map the bank mode onto per-cell JK inputs.
  always_comb begin
    j_cell = '0;
    k_cell = '0;
    case (mode_sel)
      JK_HOLD: begin
        j_cell = '0;
        k_cell = '0;
      end
      JK_JK: begin
        j_cell = j;
        k_cell = k;
      end
      JK_LOAD: begin
        j_cell = d;
        k_cell = ~d;
      end
      JK_COUNT: begin
        j_cell = toggle;
        k_cell = toggle;
      end
    endcase
  end

  // JK characteristic equation, mirrored here so the bank can see the next
  // state for the change flag without the cells exporting it.
  assign q_next = (j_cell & ~q_bits) | (~k_cell & q_bits);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= en && (q_next != q_bits);
    end
  end

  assign q       = q_bits;
  assign qb      = ~q_bits;
  assign changed = changed_reg;

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

  localparam int         WIDTH     = 4;
  localparam logic [3:0] RESET_VAL = 4'b0101;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_JK    = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;
  localparam logic [1:0] M_COUNT = 2'b11;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             changed;

  int checks_total;
  int fail_count;

  jk_reg_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .d       (d),
    .up      (up),
    .q       (q),
    .qb      (qb),
    .tc      (tc),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs were set earlier, outputs sampled 1 time unit later.
  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("[%0t] %-14s rst_n=%b en=%b mode=%b up=%b -> q=%b qb=%b tc=%b changed=%b",
             $time, what, rst_n, en, mode, up, q, qb, tc, changed);
  endtask

  initial begin
    checks_total = 0;
    fail_count   = 0;

    // 1. reset with random other inputs, then enable low
    rst_n = 1'b0;
    en    = 1'($urandom_range(0, 1));
    mode  = 2'($urandom_range(0, 3));
    j     = 4'($urandom_range(0, 15));
    k     = 4'($urandom_range(0, 15));
    d     = 4'($urandom_range(0, 15));
    up    = 1'($urandom_range(0, 1));
    #2;
    step("reset");
    check("reset_q", 32'(q), 32'(4'b0101));
    check("reset_qb", 32'(qb), 32'(4'b1010));
    check("reset_changed", 32'(changed), 32'd0);

    rst_n = 1'b1;
    en    = 1'b0;
    mode  = M_COUNT;
    up    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("en_low");
      check("en_low_q", 32'(q), 32'(4'b0101));
      check("en_low_changed", 32'(changed), 32'd0);
    end
    check("en_low_tc", 32'(tc), 32'd0);

    // 2. JK mode
    en   = 1'b1;
    mode = M_JK;
    j    = 4'b1010;
    k    = 4'b0101;
    step("jk_set_clr");
    check("jk1_q", 32'(q), 32'(4'b1010));
    check("jk1_qb", 32'(qb), 32'(4'b0101));
    check("jk1_changed", 32'(changed), 32'd1);
    j = 4'b1111;
    k = 4'b1111;
    step("jk_toggle");
    check("jk2_q", 32'(q), 32'(4'b0101));
    check("jk2_changed", 32'(changed), 32'd1);
    j = 4'b0011;
    k = 4'b0110;
    step("jk_mixed");
    check("jk3_q", 32'(q), 32'(4'b0011));
    j = 4'b0000;
    k = 4'b0000;
    step("jk_hold");
    check("jk4_q", 32'(q), 32'(4'b0011));
    check("jk4_changed", 32'(changed), 32'd0);
    mode = M_HOLD;
    j    = 4'b1111;
    k    = 4'b0000;
    step("hold");
    check("hold_q", 32'(q), 32'(4'b0011));
    check("hold_tc", 32'(tc), 32'd0);

    // 3. LOAD 1110 then count up through all-ones
    mode = M_LOAD;
    d    = 4'b1110;
    step("load");
    check("load_q", 32'(q), 32'(4'b1110));
    check("load_changed", 32'(changed), 32'd1);
    mode = M_COUNT;
    up   = 1'b1;
    step("count_up");
    check("up1_q", 32'(q), 32'(4'b1111));
    check("up1_tc", 32'(tc), 32'd1);
    step("count_up_wrap");
`ifdef JKREG_SATURATE_EN
    check("up_wrap_q", 32'(q), 32'(4'b1111));
    check("up_wrap_changed", 32'(changed), 32'd0);
    check("up_wrap_tc", 32'(tc), 32'd1);
`else
    check("up_wrap_q", 32'(q), 32'(4'b0000));
    check("up_wrap_changed", 32'(changed), 32'd1);
    check("up_wrap_tc", 32'(tc), 32'd0);
`endif

    // 4. LOAD 0001 then count down through zero
    mode = M_LOAD;
    d    = 4'b0001;
    step("load");
    check("load2_q", 32'(q), 32'(4'b0001));
    mode = M_COUNT;
    up   = 1'b0;
    step("count_down");
    check("dn1_q", 32'(q), 32'(4'b0000));
    check("dn1_tc", 32'(tc), 32'd1);
    step("count_down_wrap");
`ifdef JKREG_SATURATE_EN
    check("dn_wrap_q", 32'(q), 32'(4'b0000));
    check("dn_wrap_changed", 32'(changed), 32'd0);
`else
    check("dn_wrap_q", 32'(q), 32'(4'b1111));
    check("dn_wrap_changed", 32'(changed), 32'd1);
`endif

    // down count with a long borrow chain
    mode = M_LOAD;
    d    = 4'b1000;
    step("load");
    mode = M_COUNT;
    up   = 1'b0;
    step("count_down");
    check("borrow_q", 32'(q), 32'(4'b0111));

    // 5. count up from 0011, reset on the third edge
    mode = M_LOAD;
    d    = 4'b0011;
    step("load");
    mode = M_COUNT;
    up   = 1'b1;
    step("count_up");
    check("seq1_q", 32'(q), 32'(4'b0100));
    step("count_up");
    check("seq2_q", 32'(q), 32'(4'b0101));
    check("seq2_changed", 32'(changed), 32'd1);
    rst_n = 1'b0;
    step("reset_midcount");
    check("seq3_q", 32'(q), 32'(4'b0101));
    check("seq3_changed", 32'(changed), 32'd0);

    // 6. en toggling in count up from 0000
    rst_n = 1'b1;
    mode  = M_LOAD;
    d     = 4'b0000;
    step("load");
    mode = M_COUNT;
    up   = 1'b1;
    en   = 1'b1;
    step("count_en1");
    check("ent1_q", 32'(q), 32'(4'b0001));
    en = 1'b0;
    step("count_en0");
    check("ent2_q", 32'(q), 32'(4'b0001));
    check("ent2_changed", 32'(changed), 32'd0);
    en = 1'b1;
    step("count_en1");
    check("ent3_q", 32'(q), 32'(4'b0010));
    check("ent3_qb", 32'(qb), 32'(4'b1101));

    $display("End of test - %0d assertions evaluated, %0d failures", checks_total, fail_count);
    $finish;
  end

endmodule
